// File: rtl/range_pkg.sv
// Shared types and constants for the range statistics tracker.
// Holds the FSM state encoding and the min/max tracker reset values.
package range_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Largest representable value. The caller truncates the result to its own width.
  function automatic logic [63:0] extreme_high(input int width, input bit is_signed);
    if (is_signed) return {64{1'b1}} >> (65 - width);
    return {64{1'b1}} >> (64 - width);
  endfunction

  // Smallest representable value. The caller truncates the result to its own width.
  function automatic logic [63:0] extreme_low(input int width, input bit is_signed);
    if (is_signed) return 64'(1) << (width - 1);
    return '0;
  endfunction

endpackage

// File: rtl/range_minmax_tracker.sv
// Running minimum/maximum of a sample stream, signed or unsigned.
// Exposes the value the trackers take at the next edge so results can include the current sample.
module range_minmax_tracker
  import range_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int SIGNED = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             update,
  input  logic             data_valid,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] min_next,
  output logic [WIDTH-1:0] max_next
);

  localparam logic [WIDTH-1:0] MIN_INIT = WIDTH'(extreme_high(WIDTH, SIGNED != 0));
  localparam logic [WIDTH-1:0] MAX_INIT = WIDTH'(extreme_low(WIDTH, SIGNED != 0));

  logic [WIDTH-1:0] min_q, max_q;

  function automatic logic less_than(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (SIGNED != 0) return $signed(a) < $signed(b);
    return a < b;
  endfunction

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    min_next = min_q;
    max_next = max_q;
    if (load) begin
      min_next = data_valid ? data_in : MIN_INIT;
      max_next = data_valid ? data_in : MAX_INIT;
    end else if (update) begin
      if (less_than(data_in, min_q)) min_next = data_in;
      if (less_than(max_q, data_in)) max_next = data_in;
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      min_q <= MIN_INIT;
      max_q <= MAX_INIT;
    end else begin
      min_q <= min_next;
      max_q <= max_next;
    end
  end

endmodule

// File: rtl/range_stats_tracker.sv
// Windowed min/max/range/count tracker over a qualified sample stream.
// Results are captured on the closing edge and held until the next window opens.
module range_stats_tracker
  import range_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 8,
  parameter int SIGNED    = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 data_valid,
  input  logic                 go,
  input  logic                 finish,
  output logic [WIDTH:0]       range,
  output logic [WIDTH-1:0]     min_out,
  output logic [WIDTH-1:0]     max_out,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 result_valid,
  output logic                 empty,
  output logic                 busy,
  output logic                 debug_error
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t state_q, state_d;

  logic                 in_compute, start, close, sample, proto_err, err_q;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_next;
  logic [WIDTH-1:0]     min_next, max_next;
  logic [WIDTH:0]       min_ext, max_ext;

  assign in_compute = (state_q == COMPUTE);
  assign start      = go & ~finish & ~in_compute;
  assign close      = finish & ~go & in_compute;
  // A go that is ignored inside a window does not stop that cycle's sample from counting.
  assign sample     = data_valid & in_compute;
  assign proto_err  = (go & finish) | (go & in_compute) | (finish & ~in_compute);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = COMPUTE;
      COMPUTE: if (close) state_d = DONE;
      DONE:    if (start) state_d = COMPUTE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  range_minmax_tracker #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) u_minmax (
    .clock      (clock),
    .reset      (reset),
    .load       (start),
    .update     (sample),
    .data_valid (data_valid),
    .data_in    (data_in),
    .min_next   (min_next),
    .max_next   (max_next)
  );

  always_comb begin
    cnt_next = cnt_q;
    if (start)                            cnt_next = data_valid ? CNT_ONE : '0;
    else if (sample && cnt_q != CNT_MAX)  cnt_next = cnt_q + 1'b1;
  end

  // Extend into WIDTH+1 bits so max - min never overflows.
  assign min_ext = (SIGNED != 0) ? {min_next[WIDTH-1], min_next} : {1'b0, min_next};
  assign max_ext = (SIGNED != 0) ? {max_next[WIDTH-1], max_next} : {1'b0, max_next};

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_next;
      if (start)          err_q <= 1'b0;
      else if (proto_err) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || start) begin
      min_out      <= '0;
      max_out      <= '0;
      range        <= '0;
      result_valid <= 1'b0;
      empty        <= 1'b0;
    end else if (close) begin
      result_valid <= 1'b1;
      if (cnt_next == '0) begin
        min_out <= '0;
        max_out <= '0;
        range   <= '0;
        empty   <= 1'b1;
      end else begin
        min_out <= min_next;
        max_out <= max_next;
        range   <= max_ext - min_ext;
        empty   <= 1'b0;
      end
    end
  end

  assign count       = cnt_q;
  assign busy        = in_compute;
  assign debug_error = err_q | (go & finish);

endmodule
